// File: rtl/fixed_to_float_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// fixed_to_float_ctrl_fsm
//
// Sequencing controller for the fixed-to-float converter that follows the
// CORDIC exponential unit. A start request walks the converter through:
//   load fixed input -> load denormalised value -> let the converter's
//   registered compare settle -> load the barrel shifter -> wait for the
//   shifter -> write the float result register -> hold a done handshake.
//
// Ports
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-low reset, released synchronously
//   BEGIN_FSM  : start request (level), only looked at while idle
//   Bandcomp   : converter flag, leading-one position > EXP_REF
//   Encd       : converter leading-one position
//   EN_REG1    : enable for the fixed input register
//   EN_REGmult : enable for the denormalised-value register
//   LOAD       : barrel-shifter load
//   MS_1       : shift-amount select (1 = |Encd-EXP_REF|, 0 = no shift)
//   EN_REG2    : enable for the float output register
//   ACK_FSM    : conversion done, held until BEGIN_FSM goes low
//   BUSY       : high whenever the controller is not idle
//
// All outputs are flops decoded from the next state, so each one is valid in
// the same cycle its state is entered and no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module fixed_to_float_ctrl_fsm #(
    parameter int          WAIT_CYC = 1,      // cycles spent in SHWAIT, 1..15
    parameter int          CNT_W    = 4,      // wait counter width
    parameter logic [7:0]  EXP_REF  = 8'd26   // leading-one position needing no shift
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BEGIN_FSM,
    input  logic       Bandcomp,
    input  logic [7:0] Encd,
    output logic       EN_REG1,
    output logic       EN_REGmult,
    output logic       LOAD,
    output logic       MS_1,
    output logic       EN_REG2,
    output logic       ACK_FSM,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REG1   = 3'd1,
        S_DENORM = 3'd2,
        S_CMP    = 3'd3,
        S_SHIFT  = 3'd4,
        S_SHWAIT = 3'd5,
        S_STORE  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Terminal count of the wait counter: leave SHWAIT after WAIT_CYC cycles.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic en_reg1_q,    en_reg1_d;
    logic en_regmult_q, en_regmult_d;
    logic load_q,       load_d;
    logic ms_1_q,       ms_1_d;
    logic en_reg2_q,    en_reg2_d;
    logic ack_q,        ack_d;
    logic busy_q,       busy_d;

    // The shift direction is resolved inside the converter from its own
    // Bandcomp; the controller only needs to know whether any shift is due,
    // which Encd alone answers. The flag stays on the port list so the
    // converter interface is unchanged.
    logic bandcomp_unused;
    assign bandcomp_unused = Bandcomp;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            en_reg1_q    <= 1'b0;
            en_regmult_q <= 1'b0;
            load_q       <= 1'b0;
            ms_1_q       <= 1'b0;
            en_reg2_q    <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_reg1_q    <= en_reg1_d;
            en_regmult_q <= en_regmult_d;
            load_q       <= load_d;
            ms_1_q       <= ms_1_d;
            en_reg2_q    <= en_reg2_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        // The counter idles at zero; it only advances while waiting in
        // SHWAIT, so leaving SHWAIT clears it for the next conversion.
        cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (BEGIN_FSM) begin
                    state_d = S_REG1;
                end
            end
            S_REG1: begin
                state_d = S_DENORM;
            end
            S_DENORM: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // One idle cycle so the converter's registered compare
                // flag and Encd reflect the newly loaded mult value.
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                state_d = S_SHWAIT;
            end
            S_SHWAIT: begin
                // >= rather than == so a corrupted count cannot trap the
                // controller here.
                if (cnt_q >= WAIT_LAST) begin
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STORE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // Level handshake: wait for the requester to drop BEGIN_FSM
                // so one request never produces two conversions.
                if (!BEGIN_FSM) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state
    // ------------------------------------------------------------------
    always_comb begin
        en_reg1_d    = (state_d == S_REG1);
        en_regmult_d = (state_d == S_DENORM);
        load_d       = (state_d == S_SHIFT);
        en_reg2_d    = (state_d == S_STORE);
        ack_d        = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);

        // MS_1 samples Encd only on the CMP->SHIFT edge and is then frozen
        // until the controller goes idle again, so late Encd activity
        // cannot disturb the shift already in flight.
        ms_1_d = 1'b0;
        if (state_d == S_SHIFT && state_q == S_CMP) begin
            ms_1_d = (Encd != EXP_REF);
        end else if (state_d == S_SHWAIT || state_d == S_STORE ||
                     state_d == S_DONE) begin
            ms_1_d = ms_1_q;
        end
    end

    assign EN_REG1    = en_reg1_q;
    assign EN_REGmult = en_regmult_q;
    assign LOAD       = load_q;
    assign MS_1       = ms_1_q;
    assign EN_REG2    = en_reg2_q;
    assign ACK_FSM    = ack_q;
    assign BUSY       = busy_q;

endmodule
